// File: rtl/lock_pkg.sv
// Shared state encodings and default parameters for the door-release stage of the digital lock.
package lock_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOCKED  = 2'b00;
  localparam state_t ST_OPEN    = 2'b01;
  localparam state_t ST_LOCKOUT = 2'b10;

  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_FAIL_W         = 2;
  localparam int DEF_HOLD_CYCLES    = 20;
  localparam int DEF_LOCKOUT_CYCLES = 50;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN hold and the LOCKOUT period; done is registered and
// always equals (count == 0).
module lock_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_next;
  logic         r_done;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    if (load) begin
      w_count_next = load_val;
    end else if (en && (r_count != '0)) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_done  <= 1'b1;
    end else begin
      r_count <= w_count_next;
      r_done  <= (w_count_next == '0);
    end
  end

  assign done = r_done;

endmodule

// File: rtl/lock_door_ctrl.sv
// Door-release controller: opens on a good attempt, counts consecutive failures, and enters a
// timed lockout with a one-cycle alarm after MAX_FAILS failures.
module lock_door_ctrl
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int FAIL_W         = DEF_FAIL_W,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              unlocked,
  input  logic              attempt,
  input  logic              force_lock,
  output logic              door_release,
  output logic              lockout,
  output logic              alarm,
  output logic [FAIL_W-1:0] fail_count
);

  localparam int TIMER_W = $clog2(max2(HOLD_CYCLES, LOCKOUT_CYCLES) + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [FAIL_W-1:0]   r_fail_count;
  logic [FAIL_W-1:0]   w_fail_next;
  logic                r_door_release;
  logic                r_lockout;
  logic                r_alarm;
  logic                w_load;
  logic                w_en;
  logic [TIMER_W-1:0]  w_load_val;
  logic                w_done;

  lock_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .done     (w_done)
  );

  always_comb begin
    w_state_next = r_state;
    w_fail_next  = r_fail_count;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_en         = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (attempt) begin
          if (unlocked) begin
            w_state_next = ST_OPEN;
            w_fail_next  = '0;
            w_load       = 1'b1;
            w_load_val   = TIMER_W'(HOLD_CYCLES - 1);
          end else if (r_fail_count == FAIL_W'(MAX_FAILS - 1)) begin
            w_state_next = ST_LOCKOUT;
            w_fail_next  = FAIL_W'(MAX_FAILS);
            w_load       = 1'b1;
            w_load_val   = TIMER_W'(LOCKOUT_CYCLES - 1);
          end else begin
            w_fail_next = r_fail_count + 1'b1;
          end
        end
      end
      ST_OPEN: begin
        // Leaving OPEN early must still clear the timer so LOCKED always sees it at zero.
        if (force_lock || w_done) begin
          w_state_next = ST_LOCKED;
          w_load       = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (w_done) begin
          w_state_next = ST_LOCKED;
          w_fail_next  = '0;
          w_load       = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_LOCKED;
        w_load       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_LOCKED;
      r_fail_count   <= '0;
      r_door_release <= 1'b0;
      r_lockout      <= 1'b0;
      r_alarm        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_fail_count   <= w_fail_next;
      r_door_release <= (w_state_next == ST_OPEN);
      r_lockout      <= (w_state_next == ST_LOCKOUT);
      r_alarm        <= (r_state == ST_LOCKED) && (w_state_next == ST_LOCKOUT);
    end
  end

  assign door_release = r_door_release;
  assign lockout      = r_lockout;
  assign alarm        = r_alarm;
  assign fail_count   = r_fail_count;

endmodule

// File: tb/tb_lock_door_ctrl.sv
// Bench for lock_door_ctrl: a behavioural reference model pushes the expected outputs per cycle
// into a scoreboard queue, popped and compared one cycle later, plus per-scenario checks.
module tb_lock_door_ctrl;

  localparam int MAX_FAILS = 3;
  localparam int FAIL_W    = 2;
  localparam int HOLD      = 20;
  localparam int LOCK      = 50;

  logic              clk;
  logic              rst;
  logic              unlocked;
  logic              attempt;
  logic              force_lock;
  logic              door_release;
  logic              lockout;
  logic              alarm;
  logic [FAIL_W-1:0] fail_count;

  typedef struct packed {
    logic              door;
    logic              lock;
    logic              alarm;
    logic [FAIL_W-1:0] fail;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fails;

  // Reference model: 0 = LOCKED, 1 = OPEN, 2 = LOCKOUT; m_left = cycles of the state still to show
  int   m_state;
  int   m_left;
  int   m_fail;
  logic m_alarm;

  lock_door_ctrl #(
    .MAX_FAILS      (MAX_FAILS),
    .FAIL_W         (FAIL_W),
    .HOLD_CYCLES    (HOLD),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .unlocked     (unlocked),
    .attempt      (attempt),
    .force_lock   (force_lock),
    .door_release (door_release),
    .lockout      (lockout),
    .alarm        (alarm),
    .fail_count   (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic att, input logic unl, input logic frc);
    m_alarm = 1'b0;
    case (m_state)
      0: begin
        if (att) begin
          if (unl) begin
            m_state = 1; m_left = HOLD; m_fail = 0;
          end else if (m_fail + 1 == MAX_FAILS) begin
            m_state = 2; m_left = LOCK; m_fail = MAX_FAILS; m_alarm = 1'b1;
          end else begin
            m_fail = m_fail + 1;
          end
        end
      end
      1: begin
        if (frc) m_state = 0;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) m_state = 0;
        end
      end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_state = 0; m_fail = 0;
        end
      end
    endcase
  endtask

  // One clock of stimulus: expectation pushed at drive time, popped and compared after the edge.
  task automatic step(input logic att, input logic unl, input logic frc);
    exp_t e;
    exp_t got;
    attempt    = att;
    unlocked   = unl;
    force_lock = frc;
    model_edge(att, unl, frc);
    e.door  = (m_state == 1);
    e.lock  = (m_state == 2);
    e.alarm = m_alarm;
    e.fail  = FAIL_W'(m_fail);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got.door  = door_release;
    got.lock  = lockout;
    got.alarm = alarm;
    got.fail  = fail_count;
    e = sb_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fails++;
      $display("FAIL scoreboard @%0t: got door=%b lockout=%b alarm=%b fail=%0d, expected door=%b lockout=%b alarm=%b fail=%0d",
               $time, got.door, got.lock, got.alarm, got.fail, e.door, e.lock, e.alarm, e.fail);
    end
    attempt    = 1'b0;
    unlocked   = 1'b0;
    force_lock = 1'b0;
  endtask

  // Drops reset between edges, checks outputs cleared at once and after release.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({door_release, lockout, alarm, fail_count} !== '0) begin
      n_fails++;
      $display("FAIL reset_immediate: got door=%b lockout=%b alarm=%b fail=%0d, expected all 0",
               door_release, lockout, alarm, fail_count);
    end
    m_state = 0; m_left = 0; m_fail = 0; m_alarm = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({door_release, lockout, alarm, fail_count} !== '0) begin
      n_fails++;
      $display("FAIL reset_release: got door=%b lockout=%b alarm=%b fail=%0d, expected all 0",
               door_release, lockout, alarm, fail_count);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_success();
    int hi;
    hi = 0;
    step(1'b1, 1'b1, 1'b0);
    hi += int'(door_release);
    for (int i = 0; i < 24; i++) begin
      // Failed attempts during the hold must be ignored.
      step(i < 18 && i % 4 == 1, 1'b0, 1'b0);
      hi += int'(door_release);
    end
    n_checks++;
    if (hi != HOLD) begin
      n_fails++;
      $display("FAIL success_hold_len: got %0d cycles, expected %0d", hi, HOLD);
    end
  endtask

  task automatic test_fail_recover();
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (fail_count !== 2'd1) begin
      n_fails++;
      $display("FAIL fail_count_1: got %0d, expected 1", fail_count);
    end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (fail_count !== 2'd2) begin
      n_fails++;
      $display("FAIL fail_count_2: got %0d, expected 2", fail_count);
    end
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (door_release !== 1'b1 || fail_count !== 2'd0) begin
      n_fails++;
      $display("FAIL recover_open: got door=%b fail=%0d, expected door=1 fail=0", door_release, fail_count);
    end
    repeat (HOLD) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lockout();
    int lock_cnt;
    int alarm_cnt;
    int door_cnt;
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (alarm !== 1'b1 || lockout !== 1'b1 || fail_count !== 2'd3) begin
      n_fails++;
      $display("FAIL lockout_entry: got alarm=%b lockout=%b fail=%0d, expected 1 1 3", alarm, lockout, fail_count);
    end
    lock_cnt  = 1;
    alarm_cnt = 1;
    door_cnt  = 0;
    for (int i = 0; i < 55; i++) begin
      if (i < LOCK - 1) step(i % 2 == 0, 1'b1, i % 3 == 0);
      else              step(1'b0, 1'b0, 1'b0);
      lock_cnt  += int'(lockout);
      alarm_cnt += int'(alarm);
      door_cnt  += int'(door_release);
    end
    n_checks++;
    if (lock_cnt != LOCK || alarm_cnt != 1 || door_cnt != 0) begin
      n_fails++;
      $display("FAIL lockout_len: got lockout=%0d alarm=%0d door=%0d cycles, expected %0d 1 0",
               lock_cnt, alarm_cnt, door_cnt, LOCK);
    end
    n_checks++;
    if (fail_count !== 2'd0) begin
      n_fails++;
      $display("FAIL lockout_expiry_fail: got %0d, expected 0", fail_count);
    end
  endtask

  task automatic test_force_lock();
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (door_release !== 1'b0) begin
      n_fails++;
      $display("FAIL force_lock_open: got door=%b, expected 0", door_release);
    end
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (door_release !== 1'b0 || fail_count !== 2'd1) begin
      n_fails++;
      $display("FAIL force_lock_locked: got door=%b fail=%0d, expected door=0 fail=1", door_release, fail_count);
    end
  endtask

  task automatic test_async_reset_open();
    int hi;
    step(1'b1, 1'b1, 1'b0);
    repeat (9) step(1'b0, 1'b0, 1'b0);
    apply_reset();
    hi = 0;
    step(1'b1, 1'b1, 1'b0);
    hi += int'(door_release);
    repeat (22) begin
      step(1'b0, 1'b0, 1'b0);
      hi += int'(door_release);
    end
    n_checks++;
    if (hi != HOLD) begin
      n_fails++;
      $display("FAIL post_reset_hold_len: got %0d cycles, expected %0d", hi, HOLD);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b0;
    attempt    = 1'b0;
    unlocked   = 1'b0;
    force_lock = 1'b0;
    m_state    = 0;
    m_left     = 0;
    m_fail     = 0;
    m_alarm    = 1'b0;
    test_reset();
    test_success();
    test_fail_recover();
    test_lockout();
    test_force_lock();
    test_async_reset_open();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
